// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} kp_state_t;

    function automatic int unsigned code_of(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
        return row * cols + col;
    endfunction

    function automatic int unsigned onehot_cnt(input logic [7:0] rows);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++)
            if (rows[i]) n++;
        return n;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_divider #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     cnt_q <= '0;
        else if (cnt_q == W'(DIV - 1)) cnt_q <= '0;
        else                           cnt_q <= cnt_q + 1'b1;
    end

    assign tick_o = (cnt_q == W'(DIV - 1));

endmodule

// File: rtl/keypad_scanner.sv
// ROWS x COLS keypad scanner: column drive, row sync, debounce, auto-repeat,
// ghost rejection and a valid/ready key-event output with sticky overflow.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned CLK_HZ         = 27_000_000,
    parameter int unsigned SCAN_HZ        = 1_000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_EN      = 1,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ROWS-1:0]               filas_raw,
    output logic [COLS-1:0]               columnas,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          key_held,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW    = $clog2(ROWS * COLS);
    localparam int unsigned CLW   = $clog2(COLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned TM0   = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
    localparam int unsigned TMAX  = (TM0 > REPEAT_PERIOD) ? TM0 : REPEAT_PERIOD;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    kp_state_t         state_q, state_d;
    logic [ROWS-1:0]   rows_s1_q, rows_s2_q;
    logic [CLW-1:0]    col_q, col_d, col_adv;
    logic [RW-1:0]     row_q, row_d, samp_row;
    logic [TW-1:0]     cnt_q, cnt_d, rep_q, rep_d;
    logic              phase_q, phase_d;
    logic              held_q, held_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     code_q, code_d;
    logic              tick, single, match, emit, drop;

    tick_divider #(.DIV(DWELL)) u_tick (
        .clk_i  (clk),
        .rst_i  (reset),
        .tick_o (tick)
    );

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] x);
        return (x == {TW{1'b1}}) ? x : x + 1'b1;
    endfunction

    always_comb begin
        samp_row = '0;
        for (int i = 0; i < ROWS; i++)
            if (rows_s2_q[i]) samp_row = RW'(i);
    end

    // Multi-row samples are treated as empty so ghost patterns never register.
    assign single  = (onehot_cnt(8'(rows_s2_q)) == 32'd1);
    assign match   = single && (samp_row == row_q);
    assign col_adv = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        phase_d = phase_q;
        held_d  = held_q;
        emit    = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single) begin
                        row_d   = samp_row;
                        cnt_d   = TW'(1);
                        state_d = PRESS_DB;
                    end else begin
                        col_d = col_adv;
                    end
                end
                PRESS_DB: begin
                    if (match) begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_d >= TW'(DEBOUNCE_TICKS)) begin
                            emit    = 1'b1;
                            held_d  = 1'b1;
                            rep_d   = '0;
                            phase_d = 1'b0;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_adv;
                    end
                end
                HELD: begin
                    if (!match) begin
                        cnt_d   = TW'(1);
                        state_d = REL_DB;
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                        rep_d = sat_inc(rep_q);
                        if (rep_d >= (phase_q ? TW'(REPEAT_PERIOD) : TW'(REPEAT_DELAY))) begin
                            emit    = 1'b1;
                            rep_d   = '0;
                            phase_d = 1'b1;
                        end
                    end
                end
                REL_DB: begin
                    if (match) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_d >= TW'(DEBOUNCE_TICKS)) begin
                            held_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_adv;
                        end
                    end
                end
            endcase
        end
    end

    assign drop = emit && valid_q && !key_ready;

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (valid_q && key_ready) valid_d = 1'b0;
        if (emit && !drop) begin
            valid_d = 1'b1;
            code_d  = CW'(code_of(32'(row_d), 32'(col_q), COLS));
        end
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_s1_q <= '0;
            rows_s2_q <= '0;
            state_q   <= SCAN;
            col_q     <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            phase_q   <= 1'b0;
            held_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            rows_s1_q <= filas_raw;
            rows_s2_q <= rows_s1_q;
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            phase_q   <= phase_d;
            held_q    <= held_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            code_q    <= code_d;
        end
    end

    assign columnas  = COLS'(1) << col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: two scanners (repeat on/off) share one modelled 4x4 keypad.
module tb_keypad_scanner;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0][3:0]  keys;          // [row][col]
    logic [3:0]       filas1, filas2, col1, col2, code1, code2;
    logic             valid1, valid2, ready1, held1, held2, ovf1, ovf2, ovf_clr;
    logic [3:0]       q1[$], q2[$];
    int               checks = 0, errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        filas1 = '0;
        filas2 = '0;
        for (int r = 0; r < 4; r++) begin
            filas1[r] = |(keys[r] & col1);
            filas2[r] = |(keys[r] & col2);
        end
    end

    keypad_scanner #(.ROWS(4), .COLS(4), .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_TICKS(3),
                     .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .filas_raw(filas1), .columnas(col1), .key_code(code1),
        .key_valid(valid1), .key_ready(ready1), .key_held(held1), .overflow(ovf1), .ovf_clr(ovf_clr));

    keypad_scanner #(.ROWS(4), .COLS(4), .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_TICKS(3),
                     .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut_norep (
        .clk(clk), .reset(reset), .filas_raw(filas2), .columnas(col2), .key_code(code2),
        .key_valid(valid2), .key_ready(1'b1), .key_held(held2), .overflow(ovf2), .ovf_clr(1'b0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int n = 0;
        while (held1 !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(held1), 32'(v));
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (!reset && valid1 && ready1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut event: unexpected code %0d, nothing expected", code1);
            end else begin
                e = q1.pop_front();
                if (code1 !== e) begin
                    errors++;
                    $display("FAIL dut event code: got %0d expected %0d", code1, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!reset && valid2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL norep event: unexpected code %0d, nothing expected", code2);
            end else begin
                e = q2.pop_front();
                if (code2 !== e) begin
                    errors++;
                    $display("FAIL norep event code: got %0d expected %0d", code2, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] seen;
        logic       saw_held;
        keys = '0; ready1 = 1'b1; ovf_clr = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset columnas", 32'(col1), 32'h1);
        chk("reset valid", 32'(valid1), 0);
        chk("reset overflow", 32'(ovf1), 0);
        chk("reset held", 32'(held1), 0);
        chk("reset code", 32'(code1), 0);
        reset = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k % 10 == 5) chk("rotate", 32'(col1), 32'(4'b0001 << ((k / 10) % 4)));
        end

        // Clean press of row 2 col 1 -> code 9
        q1.push_back(4'd9); q2.push_back(4'd9);
        keys[2][1] = 1'b1;
        wait_held(1'b1, 200, "press held");
        keys[2][1] = 1'b0;
        repeat (15) @(negedge clk);
        chk("held during release debounce", 32'(held1), 1);
        wait_held(1'b0, 40, "release held");
        repeat (20) @(negedge clk);

        // Bounce: toggles every 7 cycles never give 3 matching samples in a row
        q1.push_back(4'd9); q2.push_back(4'd9);
        for (int t = 0; t < 60; t++) begin
            if (t % 7 == 0) keys[2][1] = ~keys[2][1];
            @(negedge clk);
        end
        keys[2][1] = 1'b1;
        wait_held(1'b1, 200, "bounce held");
        keys[2][1] = 1'b0;
        wait_held(1'b0, 100, "bounce release");
        chk("bounce events", 32'(q1.size()), 0);
        repeat (20) @(negedge clk);

        // Ghost: two rows in column 2
        keys[0][2] = 1'b1; keys[3][2] = 1'b1;
        seen = '0; saw_held = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            seen = seen | col1;
            if (held1) saw_held = 1'b1;
        end
        chk("ghost columns rotate", 32'(seen), 32'hF);
        chk("ghost held", 32'(saw_held), 0);
        keys = '0;
        repeat (20) @(negedge clk);

        // Repeat: code 5 held for ticks 3..12 -> events at 3, 8, 10, 12
        repeat (4) q1.push_back(4'd5);
        q2.push_back(4'd5);
        keys[1][1] = 1'b1;
        wait_held(1'b1, 200, "repeat held");
        repeat (90) @(negedge clk);
        keys[1][1] = 1'b0;
        wait_held(1'b0, 100, "repeat release");
        chk("repeat events pending", 32'(q1.size()), 0);
        chk("norep events pending", 32'(q2.size()), 0);
        repeat (20) @(negedge clk);

        // Overflow: consumer stalled, second press is dropped
        ready1 = 1'b0;
        q1.push_back(4'd3);
        q2.push_back(4'd3); q2.push_back(4'd6);
        keys[0][3] = 1'b1;
        wait_held(1'b1, 200, "ovf first held");
        chk("ovf first valid", 32'(valid1), 1);
        chk("ovf first code", 32'(code1), 3);
        keys[0][3] = 1'b0;
        wait_held(1'b0, 100, "ovf first release");
        keys[1][2] = 1'b1;
        wait_held(1'b1, 200, "ovf second held");
        repeat (2) @(negedge clk);
        chk("ovf code kept", 32'(code1), 3);
        chk("ovf flag", 32'(ovf1), 1);
        chk("ovf valid kept", 32'(valid1), 1);
        keys[1][2] = 1'b0;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf cleared", 32'(ovf1), 0);
        ready1 = 1'b1;
        @(negedge clk);
        wait_held(1'b0, 100, "ovf second release");
        chk("norep no overflow", 32'(ovf2), 0);
        repeat (20) @(negedge clk);

        // Reset while HELD, key stays down and is reported again afterwards
        q1.push_back(4'd5); q2.push_back(4'd5);
        keys[1][1] = 1'b1;
        wait_held(1'b1, 200, "pre-reset held");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid reset held", 32'(held1), 0);
        chk("mid reset columnas", 32'(col1), 32'h1);
        chk("mid reset code", 32'(code1), 0);
        chk("mid reset valid", 32'(valid1), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q1.push_back(4'd5); q2.push_back(4'd5);
        wait_held(1'b1, 200, "post-reset re-press");
        keys[1][1] = 1'b0;
        wait_held(1'b0, 100, "post-reset release");
        repeat (20) @(negedge clk);
        chk("final dut queue", 32'(q1.size()), 0);
        chk("final norep queue", 32'(q2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
